float_to_fixed_pipe: RTL

FLOAT_TO_FIXED_PIPE -- requirements
Module: float_to_fixed_pipe

---
 rtl/float_to_fixed_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/float_to_fixed_pipe.sv
// IEEE-754 float/double to signed fixed-point {INT_WID.FRA_WID} converter.
// Four enabled stages: unpack/classify, coarse shift, fine shift + round, negate/saturate.
module float_to_fixed_pipe #(
    parameter string FLOAT_FMT = "float",
    parameter int    INT_WID   = 16,
    parameter int    FRA_WID   = 16,
    localparam int   FLOAT_WID = (FLOAT_FMT == "double") ? 64 : 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clk_en,
    input  logic                 in_valid,
    input  logic [FLOAT_WID-1:0] float_val,
    output logic                 out_valid,
    output logic [INT_WID-1:0]   fixed_integer,
    output logic [FRA_WID-1:0]   fixed_fraction,
    output logic                 ovf
);
    localparam int EXP_W = (FLOAT_WID == 64) ? 11 : 8;
    localparam int MAN_W = FLOAT_WID - EXP_W - 1;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int TOT   = INT_WID + FRA_WID;
    localparam int EW    = TOT + 1 + MAN_W;
    localparam int LB    = 3;
    localparam int SW    = ($clog2(TOT + 1) > LB) ? $clog2(TOT + 1) : LB + 1;
    localparam int P_OFS = BIAS - FRA_WID - 1;
    localparam logic [TOT-1:0] MAX_P = {1'b0, {(TOT-1){1'b1}}};
    localparam logic [TOT-1:0] MIN_N = {1'b1, {(TOT-1){1'b0}}};

    // Stage 1: unpack and classify (subnormals are treated as zero)
    logic [EXP_W-1:0] w1_exp;
    logic [MAN_W-1:0] w1_frac;
    assign w1_exp  = float_val[FLOAT_WID-2 -: EXP_W];
    assign w1_frac = float_val[MAN_W-1:0];

    logic             r1_v, r1_sign, r1_zero, r1_inf, r1_nan;
    logic [EXP_W-1:0] r1_exp;
    logic [MAN_W:0]   r1_mant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1_v    <= 1'b0;
            r1_sign <= 1'b0;
            r1_zero <= 1'b0;
            r1_inf  <= 1'b0;
            r1_nan  <= 1'b0;
            r1_exp  <= '0;
            r1_mant <= '0;
        end else if (clk_en) begin
            r1_v    <= in_valid;
            r1_sign <= float_val[FLOAT_WID-1];
            r1_zero <= (w1_exp == '0);
            r1_inf  <= (w1_exp == '1) && (w1_frac == '0);
            r1_nan  <= (w1_exp == '1) && (w1_frac != '0);
            r1_exp  <= w1_exp;
            r1_mant <= {(w1_exp != '0), w1_frac};
        end
    end

    // Stage 2: w2_p is the bit index of the hidden bit in a word whose LSB is
    // the rounding bit (weight 2^-(FRA_WID+1)); out-of-range indices bypass the shifter.
    logic signed [31:0] w2_p;
    logic               w2_small, w2_big;
    logic [SW-1:0]      w2_s;
    logic [EW-1:0]      w2_ext;

    always_comb begin
        w2_p     = signed'(32'(r1_exp)) - P_OFS;
        w2_small = r1_zero || (w2_p < 0);
        w2_big   = r1_inf || (w2_p > TOT);
        w2_s     = (w2_small || w2_big) ? '0 : w2_p[SW-1:0];
        w2_ext   = {{(EW-MAN_W-1){1'b0}}, r1_mant};
    end

    logic          r2_v, r2_sign, r2_zero, r2_sat, r2_nan;
    logic [EW-1:0] r2_vec;
    logic [LB-1:0] r2_fine;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r2_v    <= 1'b0;
            r2_sign <= 1'b0;
            r2_zero <= 1'b0;
            r2_sat  <= 1'b0;
            r2_nan  <= 1'b0;
            r2_vec  <= '0;
            r2_fine <= '0;
        end else if (clk_en) begin
            r2_v    <= r1_v;
            r2_sign <= r1_sign;
            r2_zero <= w2_small && !w2_big && !r1_nan;
            r2_sat  <= w2_big;
            r2_nan  <= r1_nan;
            r2_vec  <= w2_ext << {w2_s[SW-1:LB], {LB{1'b0}}};
            r2_fine <= w2_s[LB-1:0];
        end
    end

    // Stage 3: fine shift, then ties-away rounding on the magnitude via the half bit
    logic [TOT:0] w3_win, w3_mag;

    always_comb begin
        w3_win = (TOT+1)'((r2_vec << r2_fine) >> MAN_W);
        w3_mag = {1'b0, w3_win[TOT:1]} + (TOT+1)'(w3_win[0]);
    end

    logic         r3_v, r3_sign, r3_sat, r3_nan;
    logic [TOT:0] r3_mag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r3_v    <= 1'b0;
            r3_sign <= 1'b0;
            r3_sat  <= 1'b0;
            r3_nan  <= 1'b0;
            r3_mag  <= '0;
        end else if (clk_en) begin
            r3_v    <= r2_v;
            r3_sign <= r2_sign;
            r3_sat  <= r2_sat;
            r3_nan  <= r2_nan;
            r3_mag  <= r2_zero ? '0 : w3_mag;
        end
    end

    // Stage 4: negate and saturate; NaN dominates regardless of sign
    logic [TOT-1:0] w4_word;
    logic           w4_ovf;

    always_comb begin
        w4_word = r3_mag[TOT-1:0];
        w4_ovf  = 1'b0;
        if (r3_nan) begin
            w4_word = MAX_P;
            w4_ovf  = 1'b1;
        end else if (r3_sat) begin
            w4_word = r3_sign ? MIN_N : MAX_P;
            w4_ovf  = 1'b1;
        end else if (r3_sign) begin
            if (r3_mag > {1'b0, MIN_N}) begin
                w4_word = MIN_N;
                w4_ovf  = 1'b1;
            end else begin
                w4_word = '0 - r3_mag[TOT-1:0];
            end
        end else if (r3_mag > {1'b0, MAX_P}) begin
            w4_word = MAX_P;
            w4_ovf  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid      <= 1'b0;
            fixed_integer  <= '0;
            fixed_fraction <= '0;
            ovf            <= 1'b0;
        end else if (clk_en) begin
            out_valid                       <= r3_v;
            {fixed_integer, fixed_fraction} <= w4_word;
            ovf                             <= w4_ovf;
        end
    end

endmodule
